// File: rtl/me_control.sv
`default_nettype none
// ============================================================================
// Module   : me_control
// Purpose  : Sequencer for a 16-PE full-search motion-estimation array.
//            One search walks a 13-bit counter through 4112 RUN cycles
//            (16 passes x 256 reference pixels, plus a 16-cycle tail that
//            drains the last pass). It drives the reference and search-window
//            addresses, the per-PE source selects, the PE capture strobe and
//            the comparator handshake, including the motion vector candidate.
// Ports    : clock      - rising-edge clock
//            reset      - synchronous, active-high reset
//            start      - begin one search (accepted only in IDLE)
//            BestDist   - comparator best distortion (early termination only)
//            busy       - high while searching
//            done       - one-cycle pulse when a search completes
//            AddressR   - reference-block address {row, col}
//            AddressS1  - search-window address, left half
//            AddressS2  - search-window address, right half
//            S1S2mux    - per-PE search-source select
//            pflag      - PE result-capture strobe
//            CompStart  - comparator enable (low clears its best distortion)
//            PEready    - index of the PE result under comparison
//            vectorX    - two's-complement horizontal motion candidate
//            vectorY    - two's-complement vertical motion candidate
// Options  : define ME_EARLY_TERM_EN to stop the search as soon as the
//            comparator reports a zero distortion.
// Revision : 1.0 - initial release
// ============================================================================
module me_control (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  BestDist,
  output logic        busy,
  output logic        done,
  output logic [7:0]  AddressR,
  output logic [9:0]  AddressS1,
  output logic [9:0]  AddressS2,
  output logic [15:0] S1S2mux,
  output logic        pflag,
  output logic        CompStart,
  output logic [3:0]  PEready,
  output logic [3:0]  vectorX,
  output logic [3:0]  vectorY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [12:0] c_LAST_COUNT   = 13'd4111;
  localparam logic [12:0] c_WINDOW_START = 13'd256;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [12:0] r_count;
  logic [12:0] w_count_nxt;

  logic [3:0]  w_row;
  logic [3:0]  w_col;
  logic [3:0]  w_pass;
  logic [4:0]  w_win_row;
  logic        w_run;
  logic        w_scan;
  logic        w_window;
  logic        w_early_term;
  logic [15:0] w_mux;

  assign w_row     = r_count[7:4];
  assign w_col     = r_count[3:0];
  assign w_pass    = r_count[11:8];
  assign w_win_row = {1'b0, w_pass} + {1'b0, w_row};
  assign w_run     = (r_state == ST_RUN);
  // Counts 4096..4111 only drain the last pass; no new pixels are addressed.
  assign w_scan    = w_run && !r_count[12];
  // Results of pass p-1 are compared during the first 16 cycles of pass p.
  assign w_window  = w_run && (r_count[12:8] != 5'd0) && (w_row == 4'd0);

`ifdef ME_EARLY_TERM_EN
  // A perfect match cannot be improved on, so the remaining passes are skipped.
  assign w_early_term = CompStart && (BestDist == 8'h00);
`else
  logic w_unused_bestdist;
  assign w_unused_bestdist = ^BestDist;
  assign w_early_term      = 1'b0;
`endif

  // PE i takes its sample from the S1 half until the column reaches i.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_mux
      assign w_mux[gi] = (w_col >= 4'(gi));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State / counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      ST_IDLE: begin
        w_count_nxt = '0;
        if (start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if ((r_count == c_LAST_COUNT) || w_early_term) begin
          w_state_nxt = ST_DONE;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count + 13'd1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered outputs (one cycle behind state/count)
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      pflag     <= 1'b0;
      CompStart <= 1'b0;
      AddressR  <= '0;
      AddressS1 <= '0;
      AddressS2 <= '0;
      S1S2mux   <= '0;
      PEready   <= '0;
      vectorX   <= '0;
      vectorY   <= '0;
    end else begin
      busy      <= w_run;
      done      <= (r_state == ST_DONE);
      pflag     <= w_scan && (r_count[7:0] == 8'hFF);
      // Held through DONE so the comparator keeps its result until the
      // next search clears it.
      CompStart <= (w_run && (r_count >= c_WINDOW_START)) || (r_state == ST_DONE);

      // Addresses freeze at their last scan values during the drain tail.
      if (w_scan) begin
        AddressR  <= r_count[7:0];
        AddressS1 <= {w_win_row, 1'b0, w_col};
        AddressS2 <= {w_win_row, 1'b1, w_col};
        S1S2mux   <= w_mux;
      end

      // Held outside the window so the comparator sees a stable candidate.
      if (w_window) begin
        PEready <= w_col;
        vectorX <= w_col - 4'd8;
        // (count[12:8] - 1) - 8 reduced to 4 bits.
        vectorY <= w_pass - 4'd9;
      end
    end
  end

endmodule
`default_nettype wire
